pmem_responder: RTL and testbench
=================================

PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning wait cycles before response (legal range 1..15).
REQ-002 SHALL have parameter NUM_LINES, default 16, meaning number of 128-bit lines stored (power of two, 2..256).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port pmem_read  input  1  line read request from cache.
REQ-006 SHALL have port pmem_write  input  1  line write request from cache.
REQ-007 SHALL have port pmem_address  input  16  byte address (lc3b_word); bits [3:0] ignored.
REQ-008 SHALL have port pmem_wdata  input  128  write line (mem_bus).
REQ-009 SHALL have port pmem_rdata  output  128  read line (mem_bus).
REQ-010 SHALL have port pmem_resp  output  1  single-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  high while a transaction is in flight.
REQ-012 SHALL have port err  output  1  single-cycle pulse on illegal request.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP, all outputs registered.
REQ-014 Line index SHALL be pmem_address[4 +: log2(NUM_LINES)]; higher address bits alias (modulo NUM_LINES).
REQ-015 IDLE: edge with exactly one of pmem_read/pmem_write high SHALL accept: latch op, index, wdata; load counter with LATENCY-1; go WAIT.
REQ-016 IDLE: edge with both pmem_read and pmem_write high SHALL not accept, SHALL set err high for the next cycle only, SHALL stay IDLE.
REQ-017 WAIT: counter==0 SHALL go RESP; otherwise decrement and stay.
REQ-018 On the WAIT->RESP edge: write SHALL commit latched wdata to array[index]; read SHALL load pmem_rdata from array[index].
REQ-019 pmem_resp SHALL be high exactly during RESP (one cycle), first high after LATENCY+1 edges counted from the accepting edge.
REQ-020 RESP SHALL always go to IDLE next edge; a request still high in that IDLE cycle is a new transaction (initiator must drop request on seeing pmem_resp).
REQ-021 busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-022 During WAIT/RESP, pmem_read, pmem_write, pmem_address, pmem_wdata SHALL be ignored; a request deasserted mid-transaction SHALL NOT abort it (write still commits, resp still pulses).
REQ-023 pmem_rdata SHALL hold its value except at a read's WAIT->RESP edge; writes SHALL NOT change it.
REQ-024 Read of the same line right after a write completes SHALL return the written data.

Reset
REQ-025 rst high SHALL immediately force IDLE, counter 0, pmem_resp 0, busy 0, err 0, pmem_rdata 0, all array lines 0.
REQ-026 rst asserted during WAIT SHALL abort: no commit, no pmem_resp pulse.
REQ-027 First edge after rst deasserts SHALL be able to accept a request.

Verification
REQ-028 Reset, then read 0x0000 with LATENCY=4 -> pmem_resp high 5 edges after accept, pmem_rdata=0, busy high for 5 cycles.
REQ-029 Write 0x0120, wdata=128'hDEAD..BEEF (pattern), then read 0x0120 -> rdata matches; read 0x0020 -> same data (alias, NUM_LINES=16).
REQ-030 pmem_read and pmem_write both high in IDLE -> err pulses one cycle, busy stays 0, no resp, array unchanged.
REQ-031 Write accepted, request dropped after 1 cycle, address/wdata changed -> resp still pulses at LATENCY+1, original data committed at original index.
REQ-032 rst pulsed mid-WAIT of a write to 0x0040 -> no resp; subsequent read of 0x0040 returns 0.
REQ-033 Back-to-back: read held high through resp, dropped the cycle after -> exactly two transactions, two resp pulses, separated by one IDLE cycle.

Source files
------------

// File: rtl/pmem_responder.sv
// Fixed-latency physical memory responder: stores NUM_LINES 128-bit lines and
// answers single line read/write requests after LATENCY wait cycles.
module pmem_responder #(
  parameter int LATENCY   = 4,
  parameter int NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         busy,
  output logic         err
);

  localparam int         IDX_W    = $clog2(NUM_LINES);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                           state_r;
  state_t                           state_s;
  logic [3:0]                       cnt_r;
  logic                             op_write_r;
  logic [IDX_W-1:0]                 idx_r;
  logic [127:0]                     wdata_r;
  logic [NUM_LINES-1:0][127:0]      mem_r;
  logic                             accept_s;
  logic                             illegal_s;
  logic                             finish_s;
  logic                             resp_s;
  logic                             busy_s;
  logic                             err_s;
  logic                             addr_unused_s;

  // Offset bits and aliasing upper bits never select anything.
  assign addr_unused_s = ^pmem_address;

  // Request qualification and the WAIT->RESP commit point.
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && (pmem_read ^ pmem_write);
    illegal_s = (state_r == ST_IDLE) && pmem_read && pmem_write;
    finish_s  = (state_r == ST_WAIT) && (cnt_r == 4'd0);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    resp_s = (state_s == ST_RESP);
    busy_s = (state_s != ST_IDLE);
    err_s  = illegal_s;
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_resp <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      pmem_resp <= resp_s;
      busy      <= busy_s;
      err       <= err_s;
    end
  end

  // Transaction latch and wait counter; inputs are ignored once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= 4'd0;
      op_write_r <= 1'b0;
      idx_r      <= '0;
      wdata_r    <= 128'd0;
    end else if (accept_s) begin
      cnt_r      <= CNT_LOAD;
      op_write_r <= pmem_write;
      idx_r      <= pmem_address[4 +: IDX_W];
      wdata_r    <= pmem_wdata;
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Line storage; a write lands only at the end of its wait period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r <= '0;
    end else if (finish_s && op_write_r) begin
      mem_r[idx_r] <= wdata_r;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Read data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_rdata <= 128'd0;
    end else if (finish_s && !op_write_r) begin
      pmem_rdata <= mem_r[idx_r];
    end else begin
      pmem_rdata <= pmem_rdata;
    end
  end

  pmem_responder_checker u_checker (
    .clk       (clk),
    .rst       (rst),
    .pmem_resp (pmem_resp),
    .busy      (busy),
    .err       (err)
  );

endmodule

// Protocol properties of the responder's outputs.
module pmem_responder_checker (
  input logic clk,
  input logic rst,
  input logic pmem_resp,
  input logic busy,
  input logic err
);

  a_resp_busy: assert property (@(posedge clk) disable iff (rst) pmem_resp |-> busy);
  a_resp_pulse: assert property (@(posedge clk) disable iff (rst) pmem_resp |=> !pmem_resp);
  a_err_idle: assert property (@(posedge clk) disable iff (rst) err |-> !busy);

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized bench for pmem_responder: an edge-counting transaction model is
// compared against the DUT every cycle, plus hand-computed directed scenarios.
module tb_pmem_responder;

  localparam int LAT = 4;
  localparam int NL  = 16;
  localparam logic [127:0] PAT = 128'hDEAD_0123_4567_89AB_CDEF_FEDC_BA98_BEEF;
  localparam logic [127:0] DAT_A = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DAT_B = 128'hA5A5_A5A5_0F0F_0F0F_F0F0_F0F0_5A5A_5A5A;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [127:0] model_mem [NL];
  logic [127:0] exp_rdata = 128'd0;
  logic         exp_resp  = 1'b0;
  logic         exp_busy  = 1'b0;
  logic         exp_err   = 1'b0;
  bit           active    = 1'b0;
  int           edge_n    = 0;
  bit           t_write;
  int           t_idx;
  logic [127:0] t_wdata;

  pmem_responder #(.LATENCY(LAT), .NUM_LINES(NL)) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Model: a transaction accepted at some edge responds LATENCY edges later
  // and is finished one edge after that.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NL; i++) model_mem[i] = 128'd0;
        exp_rdata = 128'd0;
        exp_resp  = 1'b0;
        exp_busy  = 1'b0;
        exp_err   = 1'b0;
        active    = 1'b0;
        edge_n    = 0;
      end else begin
        exp_err  = 1'b0;
        exp_resp = 1'b0;
        if (active) begin
          edge_n++;
          if (edge_n == LAT) begin
            exp_resp = 1'b1;
            exp_busy = 1'b1;
            if (t_write) model_mem[t_idx] = t_wdata;
            else exp_rdata = model_mem[t_idx];
          end else if (edge_n > LAT) begin
            active   = 1'b0;
            exp_busy = 1'b0;
          end else begin
            exp_busy = 1'b1;
          end
        end else if (pmem_read != pmem_write) begin
          active   = 1'b1;
          edge_n   = 0;
          t_write  = pmem_write;
          t_idx    = (int'(pmem_address) / 16) % NL;
          t_wdata  = pmem_wdata;
          exp_busy = 1'b1;
        end else begin
          exp_err  = pmem_read & pmem_write;
          exp_busy = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_resp", {127'd0, pmem_resp}, {127'd0, exp_resp});
      check("cyc_busy", {127'd0, busy}, {127'd0, exp_busy});
      check("cyc_err", {127'd0, err}, {127'd0, exp_err});
      check("cyc_rdata", pmem_rdata, exp_rdata);
    end
  end

  task automatic drive_window(input bit rd, input bit wr, input logic [15:0] addr,
                              input logic [127:0] wd, input int hold, input int window,
                              output int resp_n, output int first_resp, output int last_resp,
                              output int busy_n, output int err_n, output int idle_gap);
    bit busy_seen [0:63];
    @(negedge clk);
    #1;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    resp_n = 0; first_resp = 0; last_resp = 0; busy_n = 0; err_n = 0; idle_gap = 0;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      busy_seen[k] = busy;
      busy_n += int'(busy);
      err_n  += int'(err);
      if (pmem_resp) begin
        resp_n++;
        if (first_resp == 0) first_resp = k;
        last_resp = k;
      end
      if (k == hold) begin
        #1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'($urandom);
        pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    for (int k = first_resp + 1; k < last_resp; k++) begin
      if (!busy_seen[k]) idle_gap++;
    end
  endtask

  task automatic read_line(input logic [15:0] addr, output logic [127:0] data);
    int rn, fr, lr, bn, en, ig;
    drive_window(1'b1, 1'b0, addr, 128'd0, 1, LAT + 3, rn, fr, lr, bn, en, ig);
    data = pmem_rdata;
  endtask

  task automatic write_line(input logic [15:0] addr, input logic [127:0] data, output int first_resp);
    int rn, lr, bn, en, ig;
    drive_window(1'b0, 1'b1, addr, data, 1, LAT + 3, rn, first_resp, lr, bn, en, ig);
  endtask

  initial begin
    int rn, fr, lr, bn, en, ig;
    int r, hold, nresp;
    logic [127:0] d;

    rst = 1'b1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = 16'd0;
    pmem_wdata = 128'd0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_resp", {127'd0, pmem_resp}, 128'd0);
    check("rst_rdata", pmem_rdata, 128'd0);

    // Read of line 0 after reset: response on the fifth edge, busy five cycles.
    drive_window(1'b1, 1'b0, 16'h0000, 128'd0, 1, 8, rn, fr, lr, bn, en, ig);
    check("lat_resp_edge", 128'(fr), 128'd5);
    check("lat_resp_count", 128'(rn), 128'd1);
    check("lat_busy_cycles", 128'(bn), 128'd5);
    check("lat_rdata", pmem_rdata, 128'd0);

    // Write then read back, including an aliased address.
    write_line(16'h0120, PAT, fr);
    check("wr_resp_edge", 128'(fr), 128'd5);
    read_line(16'h0120, d);
    check("rd_0120", d, PAT);
    check("model_pat", exp_rdata, PAT);
    read_line(16'h0020, d);
    check("rd_alias_0020", d, PAT);

    // Both requests at once: one err cycle, nothing else happens.
    drive_window(1'b1, 1'b1, 16'h0120, ~PAT, 1, 4, rn, fr, lr, bn, en, ig);
    check("both_err_count", 128'(en), 128'd1);
    check("both_busy", 128'(bn), 128'd0);
    check("both_resp", 128'(rn), 128'd0);
    read_line(16'h0120, d);
    check("both_unchanged", d, PAT);

    // Dropped and scribbled request still commits the original write.
    write_line(16'h0300, DAT_A, fr);
    check("drop_resp_edge", 128'(fr), 128'd5);
    read_line(16'h0300, d);
    check("drop_commit", d, DAT_A);
    read_line(16'h0120, d);
    check("drop_other_line", d, PAT);

    // Reset in the middle of a write's wait period.
    nresp = 0;
    @(negedge clk);
    #1;
    pmem_write = 1'b1;
    pmem_address = 16'h0040;
    pmem_wdata = DAT_B;
    @(negedge clk);
    #1;
    pmem_write = 1'b0;
    @(negedge clk);
    nresp += int'(pmem_resp);
    #1;
    rst = 1'b1;
    #1;
    check("async_busy", {127'd0, busy}, 128'd0);
    check("async_rdata", pmem_rdata, 128'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      nresp += int'(pmem_resp);
    end
    check("abort_no_resp", 128'(nresp), 128'd0);
    read_line(16'h0040, d);
    check("abort_no_commit", d, 128'd0);
    read_line(16'h0120, d);
    check("abort_cleared", d, 128'd0);

    // Read held through its response and one more cycle: two transactions.
    drive_window(1'b1, 1'b0, 16'h0120, 128'd0, 7, 16, rn, fr, lr, bn, en, ig);
    check("b2b_count", 128'(rn), 128'd2);
    check("b2b_first", 128'(fr), 128'd5);
    check("b2b_second", 128'(lr), 128'd11);
    check("b2b_idle_gap", 128'(ig), 128'd1);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 99));
      hold = int'($urandom_range(1, LAT + 3));
      if (r < 3) begin
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rnd_async_resp", {127'd0, pmem_resp}, 128'd0);
        check("rnd_async_rdata", pmem_rdata, 128'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
      end else if (r < 12) begin
        drive_window(1'b1, 1'b1, 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     hold, hold + int'($urandom_range(0, LAT + 2)), rn, fr, lr, bn, en, ig);
      end else begin
        drive_window(r[0], ~r[0], 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     hold, hold + int'($urandom_range(0, LAT + 2)), rn, fr, lr, bn, en, ig);
      end
    end

    repeat (LAT + 3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
